alu_issue_stage: RTL and testbench

Sequential issue and retire stage that wraps the combinational 4-bit `alu` core. Operation requests (A, B, sel) arrive on a valid/ready interface and are buffered in a small FIFO. One request at a time is presented to the ALU through a registered operand stage. The ALU result (Y, Cout, plus a derived zero flag) is captured into a result register and offered downstream on a second valid/ready interface.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_req_fifo.sv | 60 ++++++
 rtl/alu_issue_stage.sv | 139 +++++++++++++
 tb/tb_alu_issue_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage and its clients.
//   ALU_WIDTH      default operand/result width of the alu core
//   OP_ADD..OP_OR  2-bit opcodes understood by the alu core
//   issue_state_e  issue-stage FSM states
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } issue_state_e;

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO for the ALU issue stage.
//   clk, rst_n  clock, asynchronous active-low reset (pointers/count only)
//   push        write push_data when not full
//   push_data   entry to write
//   pop         drop the head entry when not empty
//   full/empty  derived from the registered occupancy count
//   head_data   current head entry (valid when !empty)
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage holds data only; its contents are meaningless until the count says otherwise.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/retire stage around the combinational alu core.
//   in_valid/in_ready, in_a, in_b, in_sel   request handshake into the FIFO
//   alu_a, alu_b, alu_sel                   registered operands to the core
//   alu_y, alu_cout                         core result
//   out_valid/out_ready, out_y, out_cout,
//   out_zero                                result handshake to downstream
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_cout,
    output logic             out_zero
);

    localparam int DW = 2*WIDTH + 2;

    issue_state_e     state_q;
    issue_state_e     state_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [DW-1:0]    fifo_head;
    logic             fifo_pop;
    logic             capture;
    logic             slot_free;

    logic [WIDTH-1:0] op_a_p0;
    logic [WIDTH-1:0] op_b_p0;
    logic [1:0]       op_sel_p0;

    logic [WIDTH-1:0] res_y_p1;
    logic             res_cout_p1;
    logic             res_zero_p1;
    logic             vld_p1;

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data ({in_sel, in_a, in_b}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head)
    );

    assign in_ready  = !fifo_full;
    assign slot_free = !vld_p1 || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!fifo_empty) state_d = EXEC;
            EXEC, HOLD: begin
                if (slot_free) state_d = fifo_empty ? IDLE : EXEC;
                else           state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: fifo_pop = !fifo_empty;
            EXEC, HOLD: begin
                capture  = slot_free;
                fifo_pop = slot_free && !fifo_empty;
            end
            default: ;
        endcase
    end

    // ---- stage p0: operand registers driving the core ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_p0   <= '0;
            op_b_p0   <= '0;
            op_sel_p0 <= '0;
        end else if (fifo_pop) begin
            {op_sel_p0, op_a_p0, op_b_p0} <= fifo_head;
        end
    end

    assign alu_a   = op_a_p0;
    assign alu_b   = op_b_p0;
    assign alu_sel = op_sel_p0;

    // ---- stage p1: result register offered downstream ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_y_p1    <= '0;
            res_cout_p1 <= 1'b0;
            res_zero_p1 <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            if (capture) begin
                res_y_p1    <= alu_y;
                res_cout_p1 <= alu_cout;
                res_zero_p1 <= (alu_y == '0);
                vld_p1      <= 1'b1;
            end else if (out_ready) begin
                vld_p1      <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_y     = res_y_p1;
    assign out_cout  = res_cout_p1;
    assign out_zero  = res_zero_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural alu core attached.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [1:0] in_sel = '0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_sel;
    logic [3:0] alu_y;
    logic       alu_cout;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_y;
    logic       out_cout;
    logic       out_zero;

    int total = 0;
    int bad   = 0;

    logic [5:0] sb [$];

    logic       s_valid, s_rdy, s_acc, s_cout, s_zero;
    logic [3:0] s_y;

    alu_issue_stage #(.DEPTH(4), .WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .alu_cout  (alu_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_cout  (out_cout),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Behavioural core: returns {cout, y}; SUB carries out of a + ~b + 1.
    function automatic logic [4:0] core_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        logic [4:0] r;
        case (s)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} + {1'b0, ~b} + 5'd1;
            OP_AND:  r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

    always_comb {alu_cout, alu_y} = core_fn(alu_a, alu_b, alu_sel);

    // Expected {cout, y, zero} for a request.
    function automatic logic [5:0] ref_res(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        logic [4:0] r;
        r = core_fn(a, b, s);
        return {r[4], r[3:0], (r[3:0] == 4'd0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One cycle: drive at negedge, sample #1 later, score transfers, then wait the edge.
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] s, input logic ordy);
        logic [5:0] e;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sel    = s;
        out_ready = ordy;
        #1;
        s_valid = out_valid;
        s_rdy   = in_ready;
        s_y     = out_y;
        s_cout  = out_cout;
        s_zero  = out_zero;
        s_acc   = v && in_ready;
        if (out_valid && ordy) begin
            if (sb.size() == 0) begin
                chk("sb_has_entry", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("result", {26'd0, out_cout, out_y, out_zero}, {26'd0, e});
            end
        end
        if (s_acc) sb.push_back(ref_res(a, b, s));
        @(posedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'd0, 4'd0, OP_ADD, ordy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ta [8];
        logic [3:0] tb_ [8];
        logic [1:0] ts [8];
        logic [3:0] y0;
        logic       have_y;
        int         n;

        ta  = '{4'h1, 4'h9, 4'h7, 4'hC, 4'h5, 4'hF, 4'h3, 4'h8};
        tb_ = '{4'h2, 4'h3, 4'h7, 4'h6, 4'hA, 4'h1, 4'h3, 4'h8};
        ts  = '{OP_ADD, OP_SUB, OP_SUB, OP_AND, OP_OR, OP_ADD, OP_AND, OP_ADD};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_ops",   {22'd0, alu_a, alu_b, alu_sel}, 32'd0);
        chk("rst_out_res",   {26'd0, out_y, out_cout, out_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single ADD: 0011 + 0001, valid two cycles after acceptance
        step(1'b1, 4'b0011, 4'b0001, OP_ADD, 1'b1);
        chk("add_accept", 32'(s_acc), 32'd1);
        idle(1'b1);
        chk("add_lat_k", 32'(s_valid), 32'd0);
        idle(1'b1);
        chk("add_lat_k1", 32'(s_valid), 32'd0);
        idle(1'b1);
        chk("add_lat_k2", 32'(s_valid), 32'd1);
        chk("add_y_c_z", {26'd0, s_y, s_cout, s_zero}, {26'd0, 4'b0100, 1'b0, 1'b0});
        idle(1'b1);

        // Back-to-back SUB / AND / OR
        step(1'b1, 4'b0100, 4'b0001, OP_SUB, 1'b1);
        step(1'b1, 4'b1100, 4'b1010, OP_AND, 1'b1);
        step(1'b1, 4'b1100, 4'b1010, OP_OR,  1'b1);
        idle(1'b1);
        chk("b2b_sub", {27'd0, s_valid, s_y}, {27'd0, 1'b1, 4'b0011});
        idle(1'b1);
        chk("b2b_and", {27'd0, s_valid, s_y}, {27'd0, 1'b1, 4'b1000});
        idle(1'b1);
        chk("b2b_or",  {27'd0, s_valid, s_y}, {27'd0, 1'b1, 4'b1110});
        idle(1'b1);
        chk("b2b_done", 32'(s_valid), 32'd0);

        // Carry and zero: 1111 + 0001
        step(1'b1, 4'b1111, 4'b0001, OP_ADD, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("cz_y_c_z", {26'd0, s_y, s_cout, s_zero}, {26'd0, 4'b0000, 1'b1, 1'b1});
        idle(1'b1);

        // Backpressure: continuous requests with out_ready low
        n = 0;
        have_y = 1'b0;
        y0 = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, ta[n], tb_[n], ts[n], 1'b0);
            if (s_acc) n++;
            if (s_valid && !have_y) begin
                y0 = s_y;
                have_y = 1'b1;
            end
        end
        chk("bp_accepts",   32'(n), 32'd6);
        chk("bp_in_ready",  32'(s_rdy), 32'd0);
        chk("bp_out_valid", 32'(s_valid), 32'd1);
        chk("bp_hold_y",    32'(s_y), 32'(y0));

        // Full FIFO with simultaneous pop: no push on the pop cycle, push on the next
        step(1'b1, ta[n], tb_[n], ts[n], 1'b1);
        chk("full_pop_no_push", 32'(s_acc), 32'd0);
        step(1'b1, ta[n], tb_[n], ts[n], 1'b1);
        chk("push_after_pop", 32'(s_acc), 32'd1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1);
        chk("bp_drained", 32'(sb.size()), 32'd0);
        idle(1'b1);

        // Reset while holding a result with the FIFO partly full
        for (int i = 0; i < 4; i++) step(1'b1, ta[i], tb_[i], ts[i], 1'b0);
        idle(1'b0);
        idle(1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("no_stale", 32'(s_valid), 32'd0);
        end

        // Operation resumes after reset
        step(1'b1, 4'b0101, 4'b0010, OP_ADD, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
